// File: rtl/panel_input_conditioner_pkg.sv
// Shared definitions for the front-panel input conditioner: counter sizing,
// default 27 MHz timing constants and the per-channel debounce state type.
package panel_pkg;

  localparam int DEBOUNCE_10MS = 270000;
  localparam int REPEAT_500MS  = 13500000;
  localparam int REPEAT_100MS  = 2700000;

  typedef enum logic {STABLE, SETTLING} deb_state_e;

  // Bits needed for a counter sized by n, never narrower than one bit.
  function automatic int cnt_width(int n);
    return $clog2((n < 2) ? 2 : n);
  endfunction

endpackage

// File: rtl/panel_input_conditioner_channel.sv
// One conditioned input: 2-flop synchroniser, polarity fix, debounce FSM,
// registered edge pulses and optional auto-repeat press ticks.
module input_debounce_channel
  import panel_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS,
  parameter bit ACTIVE_LOW      = 1'b0,
  parameter bit REPEAT_EN       = 1'b0,
  parameter int REPEAT_DELAY    = REPEAT_500MS,
  parameter int REPEAT_PERIOD   = REPEAT_100MS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_in,
  output logic level,
  output logic rise,
  output logic fall,
  output logic press
);

  localparam int DW   = cnt_width(DEBOUNCE_CYCLES);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = cnt_width(RMAX);

  localparam logic [DW-1:0] DEB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);
  localparam logic [RW-1:0] RPT_SAT     = RW'(RMAX - 1);

  logic [1:0]    sync_q;
  logic          s;
  deb_state_e    state, state_nxt;
  logic [DW-1:0] cnt, cnt_nxt;
  logic          accept;
  logic [RW-1:0] rpt_cnt;
  logic          rpt_first;
  logic          tick;

  // Synchroniser idles at the inactive pin level so reset never looks like a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= {2{ACTIVE_LOW}};
    else        sync_q <= {sync_q[0], raw_in};
  end

  assign s = sync_q[1] ^ ACTIVE_LOW;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    case (state)
      STABLE: begin
        if (s != level) begin
          state_nxt = SETTLING;
          cnt_nxt   = cnt + 1'b1;
        end
      end
      SETTLING: begin
        if (s == level) begin
          state_nxt = STABLE;
          cnt_nxt   = '0;
        end else if (cnt == DEB_LAST) begin
          accept    = 1'b1;
          state_nxt = STABLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = STABLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // A tick coinciding with the release edge is suppressed.
  assign tick = REPEAT_EN && level && !accept &&
                (rpt_first ? (rpt_cnt == DELAY_LAST) : (rpt_cnt == PERIOD_LAST));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= STABLE;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
      press <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      level <= level ^ accept;
      rise  <= accept & ~level;
      fall  <= accept & level;
      press <= (accept & ~level) | tick;
    end
  end

  // Repeat counter restarts on every accepted edge and holds at zero while released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_cnt   <= '0;
      rpt_first <= 1'b1;
    end else if (!REPEAT_EN || !level || accept) begin
      rpt_cnt   <= '0;
      rpt_first <= 1'b1;
    end else if (tick) begin
      rpt_cnt   <= '0;
      rpt_first <= 1'b0;
    end else if (rpt_cnt != RPT_SAT) begin
      rpt_cnt <= rpt_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/panel_input_conditioner.sv
// Front-panel input conditioner: one independent debounce channel per button
// or switch, with a combined "anything held" indication.
module panel_input_conditioner
  import panel_pkg::*;
#(
  parameter int                  CHANNELS        = 8,
  parameter int                  DEBOUNCE_CYCLES = DEBOUNCE_10MS,
  parameter logic [CHANNELS-1:0] ACTIVE_LOW_MASK = '0,
  parameter logic [CHANNELS-1:0] REPEAT_MASK     = '0,
  parameter int                  REPEAT_DELAY    = REPEAT_500MS,
  parameter int                  REPEAT_PERIOD   = REPEAT_100MS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] raw_in,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] press,
  output logic                any_active
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    input_debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW_MASK[i]),
      .REPEAT_EN      (REPEAT_MASK[i]),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .raw_in(raw_in[i]),
      .level (level[i]),
      .rise  (rise[i]),
      .fall  (fall[i]),
      .press (press[i])
    );
  end

  assign any_active = |level;

endmodule

// File: tb/tb_panel_input_conditioner.sv
// Directed-vector bench for panel_input_conditioner: 4 channels, 4-cycle
// debounce, channel 1 active-low, channel 2 auto-repeating (10 then every 3).
module tb_panel_input_conditioner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] raw_in;
  logic [3:0] level, rise, fall, press;
  logic       any_active;
  logic [3:0] seen;
  logic [2:0] exp_ch2;

  int vector_count = 0;
  int miss_count   = 0;

  panel_input_conditioner #(
    .CHANNELS       (4),
    .DEBOUNCE_CYCLES(4),
    .ACTIVE_LOW_MASK(4'b0010),
    .REPEAT_MASK    (4'b0100),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .raw_in    (raw_in),
    .level     (level),
    .rise      (rise),
    .fall      (fall),
    .press     (press),
    .any_active(any_active)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vector_count++;
    if (observed !== expected) begin
      miss_count++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] v);
    raw_in = v;
  endtask

  // Advance n rising edges, leaving the caller 1 ns after the last one.
  task automatic stepEdges(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(4'b1111);
    stepEdges(3);
    checkOutput("rst_level", level, 4'b0000);
    checkOutput("rst_rise", rise, 4'b0000);
    checkOutput("rst_fall", fall, 4'b0000);
    checkOutput("rst_press", press, 4'b0000);
    checkOutput("rst_any", any_active, 1'b0);

    // Inputs held through reset are accepted on the 6th edge after release
    rst_n = 1'b1;
    stepEdges(5);
    checkOutput("post_rst_e5_level", level, 4'b0000);
    stepEdges(1);
    checkOutput("post_rst_e6_level", level, 4'b1101);
    checkOutput("post_rst_e6_rise", rise, 4'b1101);
    checkOutput("post_rst_e6_press", press, 4'b1101);
    checkOutput("post_rst_e6_fall", fall, 4'b0000);
    checkOutput("post_rst_e6_any", any_active, 1'b1);
    stepEdges(1);
    checkOutput("post_rst_e7_rise", rise, 4'b0000);
    checkOutput("post_rst_e7_press", press, 4'b0000);

    applyStimulus(4'b0010);
    stepEdges(6);
    checkOutput("all_release_level", level, 4'b0000);
    checkOutput("all_release_fall", fall, 4'b1101);
    checkOutput("all_release_press", press, 4'b0000);
    stepEdges(1);
    checkOutput("all_release_fall_1cyc", fall, 4'b0000);

    // Clean press on channel 0
    applyStimulus(4'b0011);
    stepEdges(5);
    checkOutput("ch0_e5_level", level, 4'b0000);
    stepEdges(1);
    checkOutput("ch0_e6_level", level, 4'b0001);
    checkOutput("ch0_e6_rise", rise, 4'b0001);
    checkOutput("ch0_e6_press", press, 4'b0001);
    checkOutput("ch0_e6_fall", fall, 4'b0000);
    stepEdges(1);
    checkOutput("ch0_e7_rise", rise, 4'b0000);
    checkOutput("ch0_e7_press", press, 4'b0000);
    applyStimulus(4'b0010);
    stepEdges(6);
    checkOutput("ch0_release_fall", fall, 4'b0001);
    checkOutput("ch0_release_level", level, 4'b0000);

    // Three-cycle glitch on channel 3 must vanish entirely
    seen = '0;
    applyStimulus(4'b1010);
    for (int k = 0; k < 3; k++) begin
      stepEdges(1);
      seen |= level | rise | fall | press;
    end
    applyStimulus(4'b0010);
    for (int k = 0; k < 8; k++) begin
      stepEdges(1);
      seen |= level | rise | fall | press;
    end
    checkOutput("glitch3_no_activity", seen, 4'b0000);

    // Four-cycle pulse is just long enough to be accepted
    applyStimulus(4'b1010);
    stepEdges(4);
    applyStimulus(4'b0010);
    stepEdges(2);
    checkOutput("pulse4_e6_level", level, 4'b1000);
    checkOutput("pulse4_e6_rise", rise, 4'b1000);
    stepEdges(4);
    checkOutput("pulse4_e10_fall", fall, 4'b1000);
    checkOutput("pulse4_e10_level", level, 4'b0000);

    // Active-low channel 1
    applyStimulus(4'b0000);
    stepEdges(5);
    checkOutput("ch1_e5_level", level, 4'b0000);
    stepEdges(1);
    checkOutput("ch1_e6_level", level, 4'b0010);
    checkOutput("ch1_e6_rise", rise, 4'b0010);
    checkOutput("ch1_e6_press", press, 4'b0010);
    applyStimulus(4'b0010);
    stepEdges(6);
    checkOutput("ch1_release_fall", fall, 4'b0010);
    checkOutput("ch1_release_press", press, 4'b0000);
    stepEdges(1);
    checkOutput("ch1_release_fall_1cyc", fall, 4'b0000);

    // Auto-repeat on channel 2: release driven after k=28 gives fall at k=34
    applyStimulus(4'b0110);
    stepEdges(6);
    for (int k = 0; k <= 40; k++) begin
      if (k > 0) stepEdges(1);
      exp_ch2[2] = (k == 0);
      exp_ch2[1] = (k == 34);
      exp_ch2[0] = (k == 0) || (k >= 10 && k <= 31 && ((k - 10) % 3) == 0);
      checkOutput($sformatf("repeat_k%0d_rise_fall_press", k),
                  {rise[2], fall[2], press[2]}, exp_ch2);
      if (k == 28) applyStimulus(4'b0010);
    end
    checkOutput("repeat_end_level", level, 4'b0000);

    // Asynchronous reset while channel 0 is mid-settle and channel 3 is held
    applyStimulus(4'b1010);
    stepEdges(6);
    checkOutput("pre_reset_level", level, 4'b1000);
    applyStimulus(4'b1011);
    stepEdges(4);
    rst_n = 1'b0;
    #2;
    checkOutput("async_rst_level", level, 4'b0000);
    checkOutput("async_rst_any", any_active, 1'b0);
    stepEdges(2);
    rst_n = 1'b1;
    stepEdges(5);
    checkOutput("rerelease_e5_level", level, 4'b0000);
    stepEdges(1);
    checkOutput("rerelease_e6_level", level, 4'b1001);
    checkOutput("rerelease_e6_rise", rise, 4'b1001);
    checkOutput("rerelease_e6_press", press, 4'b1001);

    $display("== %0d vectors applied, %0d miscompares ==", vector_count, miss_count);
    $finish;
  end

endmodule
